frequency_divider: RTL
======================

FREQUENCY_DIVIDER -- requirements
Module: frequency_divider

Interface
REQ-001 Parameter CNT_W, default 16, SHALL be the width of the half-period counter and must hold the largest table entry.
REQ-002 clk  in  1  SHALL be the single clock; every register updates on its rising edge.
REQ-003 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-004 enable  in  1  SHALL be the mode enable; high means generate, low means idle.
REQ-005 sel  in  4  SHALL be the frequency index from the upstream up/down selector, legal range 0..8.
REQ-006 wave  out  1  SHALL be the registered square-wave output.
REQ-007 tick  out  1  SHALL be a registered one-cycle pulse on every wave toggle.
REQ-008 active_sel  out  4  SHALL be the index currently in effect.

Function
REQ-009 Clamp: sel values 9..15 SHALL be treated as 8; active_sel SHALL never exceed 8.
REQ-010 Half-period table (clk cycles, 100 MHz basis) for idx 0..8 SHALL be 50000, 25000, 10000, 5000, 2500, 1000, 500, 250, 100, giving 1, 2, 5, 10, 20, 50, 100, 200, 500 kHz.
REQ-011 State SHALL be cnt[CNT_W-1:0], wave, tick and active_sel only.
REQ-012 Idle (enable=0): cnt<=0, wave<=0, tick<=0, active_sel<=clamp(sel) every cycle.
REQ-013 Run (enable=1), cnt != HALF[active_sel]-1: cnt<=cnt+1, tick<=0, wave and active_sel held.
REQ-014 Boundary (enable=1), cnt == HALF[active_sel]-1: cnt<=0, wave<=~wave, tick<=1, active_sel<=clamp(sel).
REQ-015 Period of wave SHALL be exactly 2*HALF[active_sel] cycles at 50% duty.
REQ-016 After enable rises with wave=0, the first rising edge of wave SHALL occur HALF cycles later.
REQ-017 tick SHALL be high in the same cycle that wave first shows its new value.
REQ-018 Default (macro absent): a change of sel while running SHALL take effect only at the next boundary, so no half-period is shortened or lengthened mid-count.
REQ-019 enable falling mid-count SHALL force idle values on the next edge, regardless of cnt.

Reset
REQ-020 rst=1 SHALL set cnt=0, wave=0, tick=0, active_sel=0 on the next edge.
REQ-021 rst SHALL override enable, sel and any pending boundary.
REQ-022 After release, behaviour SHALL follow REQ-012..014 from cnt=0.

Configuration
REQ-023 Macro FREQ_DIV_RESTART_EN SHALL select immediate retune.
REQ-024 Defined: when enable=1, not at a boundary, and clamp(sel) != active_sel: next edge cnt<=0, active_sel<=clamp(sel), wave held, tick<=0.
REQ-025 Defined: if a boundary and a sel change coincide, boundary behaviour (REQ-014) SHALL apply.
REQ-026 Undefined: behaviour SHALL be exactly REQ-018, and the retune logic SHALL not be synthesised.

Structure
REQ-027 Package freq_div_pkg SHALL hold SEL_MAX=8, the 9-entry HALF table constant, and a clamp/lookup function.
REQ-028 The block is a single module; no sub-module is warranted.

Verification
REQ-029 Reset, then enable=1, sel=8: wave rises at cycle 100, falls at cycle 200, tick pulses each time, period 200 cycles.
REQ-030 sel=15 with enable=1: active_sel=8 and period 200 cycles.
REQ-031 Macro absent; running sel=8, change sel to 7 at cnt=40: current half-period still ends at 100, following half-period is 250, active_sel becomes 7 at the boundary.
REQ-032 Macro defined, same stimulus as REQ-031: the cycle after the change has cnt=0, active_sel=7, wave unchanged; next toggle 250 cycles later.
REQ-033 enable dropped at cnt=50 with wave=1: next edge wave=0, cnt=0; re-enable gives first rise 100 cycles later.
REQ-034 rst asserted in the same cycle as a boundary: wave=0, tick=0, cnt=0, active_sel=0; no toggle observed.

Source files
------------

// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the frequency divider.
// Holds the half-period table, SEL_MAX and the clamp/lookup functions.
package freq_div_pkg;

    localparam int unsigned SEL_MAX = 8;

    // Half-period in clk cycles at 100 MHz: 1,2,5,10,20,50,100,200,500 kHz
    localparam int unsigned HALF [0:SEL_MAX] = '{
        50000, 25000, 10000, 5000, 2500, 1000, 500, 250, 100
    };

    typedef logic [3:0] sel_t;

    function automatic sel_t clamp_sel(input sel_t s);
        return (s > sel_t'(SEL_MAX)) ? sel_t'(SEL_MAX) : s;
    endfunction

    function automatic int unsigned half_of(input sel_t idx);
        return HALF[clamp_sel(idx)];
    endfunction

endpackage

// File: rtl/frequency_divider.sv
// Square-wave generator selecting one of nine tones by half-period table.
// Ports: clk, rst (sync, active-high), enable, sel[3:0] -> wave, tick, active_sel[3:0].
// Define FREQ_DIV_RESTART_EN to retune immediately on a sel change.
module frequency_divider
    import freq_div_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] sel,
    output logic       wave,
    output logic       tick,
    output logic [3:0] active_sel
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] last;
    logic [3:0]       sel_c;
    logic             at_bnd;

    assign sel_c  = clamp_sel(sel);
    assign last   = CNT_W'(half_of(active_sel) - 1);
    assign at_bnd = (cnt == last);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            wave       <= 1'b0;
            tick       <= 1'b0;
            active_sel <= '0;
        end else if (!enable) begin
            cnt        <= '0;
            wave       <= 1'b0;
            tick       <= 1'b0;
            active_sel <= sel_c;
        end else if (at_bnd) begin
            // A new selection is only adopted here so half-periods stay whole
            cnt        <= '0;
            wave       <= ~wave;
            tick       <= 1'b1;
            active_sel <= sel_c;
`ifdef FREQ_DIV_RESTART_EN
        end else if (sel_c != active_sel) begin
            // Retune now: restart the count, keep the current wave level
            cnt        <= '0;
            tick       <= 1'b0;
            active_sel <= sel_c;
`endif
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule
